// File: rtl/roce_conn_pkg.sv
// Shared constants, record layout and packing helper for the RoCE
// connection-metadata protocol (transmit and receive sides).
package roce_conn_pkg;

  localparam int REC_BYTES = 44;
  localparam int REC_BITS  = REC_BYTES * 8;
  localparam logic [15:0] UDP_LEN = 16'd52;

  localparam int BEATS = 6;
  localparam logic [2:0] LAST_BEAT = 3'd5;
  localparam logic [7:0] LAST_KEEP = 8'h0F;

  localparam int OFS_QP_FLAGS = 0;
  localparam int OFS_REM_QPN  = 1;
  localparam int OFS_LOC_QPN  = 4;
  localparam int OFS_REM_PSN  = 7;
  localparam int OFS_LOC_PSN  = 10;
  localparam int OFS_R_KEY    = 13;
  localparam int OFS_BASE     = 17;
  localparam int OFS_TX_FLAGS = 25;
  localparam int OFS_REM_IP   = 26;
  localparam int OFS_OFFSET   = 30;
  localparam int OFS_DMA_LEN  = 38;
  localparam int OFS_UDP_PORT = 42;

  localparam int FLG_QP_VALID = 0;
  localparam int FLG_TX_VALID = 0;
  localparam int FLG_TX_START = 1;
  localparam int FLG_TX_WTYPE = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_PAYLOAD
  } tx_state_t;

  typedef struct packed {
    logic        qp_info_valid;
    logic [23:0] rem_qpn;
    logic [23:0] loc_qpn;
    logic [23:0] rem_psn;
    logic [23:0] loc_psn;
    logic [31:0] r_key;
    logic [63:0] rem_base_addr;
    logic        txmeta_valid;
    logic        txmeta_start;
    logic        txmeta_write_type;
    logic [31:0] rem_ip_addr;
    logic [63:0] rem_addr_offset;
    logic [31:0] dma_length;
    logic [15:0] rem_udp_port;
  } conn_req_t;

  // Record byte k lives at bits [8k+7:8k]; fields are big-endian.
  function automatic logic [REC_BITS-1:0] put_be(
    input logic [REC_BITS-1:0] rec,
    input int                  ofs,
    input int                  n,
    input logic [63:0]         v
  );
    logic [REC_BITS-1:0] r;
    r = rec;
    for (int i = 0; i < n; i++) begin
      r[8*(ofs+i) +: 8] = v[8*(n-1-i) +: 8];
    end
    return r;
  endfunction

  function automatic logic [REC_BITS-1:0] pack_record(
    input conn_req_t q
  );
    logic [REC_BITS-1:0] r;
    logic [7:0]          qf;
    logic [7:0]          tf;
    qf = '0;
    tf = '0;
    qf[FLG_QP_VALID] = q.qp_info_valid;
    tf[FLG_TX_VALID] = q.txmeta_valid;
    tf[FLG_TX_START] = q.txmeta_start;
    tf[FLG_TX_WTYPE] = q.txmeta_write_type;
    r = '0;
    r = put_be(r, OFS_QP_FLAGS, 1, 64'(qf));
    r = put_be(r, OFS_REM_QPN,  3, 64'(q.rem_qpn));
    r = put_be(r, OFS_LOC_QPN,  3, 64'(q.loc_qpn));
    r = put_be(r, OFS_REM_PSN,  3, 64'(q.rem_psn));
    r = put_be(r, OFS_LOC_PSN,  3, 64'(q.loc_psn));
    r = put_be(r, OFS_R_KEY,    4, 64'(q.r_key));
    r = put_be(r, OFS_BASE,     8, q.rem_base_addr);
    r = put_be(r, OFS_TX_FLAGS, 1, 64'(tf));
    r = put_be(r, OFS_REM_IP,   4, 64'(q.rem_ip_addr));
    r = put_be(r, OFS_OFFSET,   8, q.rem_addr_offset);
    r = put_be(r, OFS_DMA_LEN,  4, 64'(q.dma_length));
    r = put_be(r, OFS_UDP_PORT, 2, 64'(q.rem_udp_port));
    return r;
  endfunction

endpackage

// File: rtl/udp_roce_connection_transmitter_64.sv
// Packs one connection request into the 44-byte metadata record and
// sends it as a UDP header plus six 64-bit AXI-Stream beats.
module udp_roce_connection_transmitter_64
  import roce_conn_pkg::*;
#(
  parameter logic [15:0] SRC_UDP_PORT  = 16'h4321,
  parameter logic [15:0] DEST_UDP_PORT = 16'h4321,
  parameter logic [7:0]  IP_TTL        = 8'd64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_req_valid,
  output logic        s_req_ready,
  input  logic        s_qp_info_valid,
  input  logic [23:0] s_rem_qpn,
  input  logic [23:0] s_loc_qpn,
  input  logic [23:0] s_rem_psn,
  input  logic [23:0] s_loc_psn,
  input  logic [31:0] s_r_key,
  input  logic [63:0] s_rem_base_addr,
  input  logic        s_txmeta_valid,
  input  logic        s_txmeta_start,
  input  logic        s_txmeta_write_type,
  input  logic [31:0] s_rem_ip_addr,
  input  logic [63:0] s_rem_addr_offset,
  input  logic [31:0] s_dma_length,
  input  logic [15:0] s_rem_udp_port,
  input  logic [31:0] s_source_ip,
  input  logic [31:0] s_dest_ip,
  output logic        m_udp_hdr_valid,
  input  logic        m_udp_hdr_ready,
  output logic [5:0]  m_ip_dscp,
  output logic [1:0]  m_ip_ecn,
  output logic [7:0]  m_ip_ttl,
  output logic [31:0] m_ip_source_ip,
  output logic [31:0] m_ip_dest_ip,
  output logic [15:0] m_udp_source_port,
  output logic [15:0] m_udp_dest_port,
  output logic [15:0] m_udp_length,
  output logic [15:0] m_udp_checksum,
  output logic [63:0] m_udp_payload_axis_tdata,
  output logic [7:0]  m_udp_payload_axis_tkeep,
  output logic        m_udp_payload_axis_tvalid,
  input  logic        m_udp_payload_axis_tready,
  output logic        m_udp_payload_axis_tlast,
  output logic        m_udp_payload_axis_tuser,
  output logic        busy
);

  tx_state_t           state_q;
  tx_state_t           state_d;
  logic [2:0]          ptr_q;
  logic [2:0]          ptr_d;
  logic                accept;
  conn_req_t           req;
  logic [REC_BITS-1:0] rec_q;
  logic [31:0]         src_q;
  logic [31:0]         dst_q;

  assign req = '{
    qp_info_valid:     s_qp_info_valid,
    rem_qpn:           s_rem_qpn,
    loc_qpn:           s_loc_qpn,
    rem_psn:           s_rem_psn,
    loc_psn:           s_loc_psn,
    r_key:             s_r_key,
    rem_base_addr:     s_rem_base_addr,
    txmeta_valid:      s_txmeta_valid,
    txmeta_start:      s_txmeta_start,
    txmeta_write_type: s_txmeta_write_type,
    rem_ip_addr:       s_rem_ip_addr,
    rem_addr_offset:   s_rem_addr_offset,
    dma_length:        s_dma_length,
    rem_udp_port:      s_rem_udp_port
  };

  assign accept = s_req_valid & s_req_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_HDR;
      end
      S_HDR: begin
        if (m_udp_hdr_ready) begin
          state_d = S_PAYLOAD;
          ptr_d   = '0;
        end
      end
      S_PAYLOAD: begin
        if (m_udp_payload_axis_tready) begin
          if (ptr_q == LAST_BEAT) begin
            state_d = S_IDLE;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Handshake outputs are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q                   <= S_IDLE;
      ptr_q                     <= '0;
      s_req_ready               <= 1'b0;
      busy                      <= 1'b0;
      m_udp_hdr_valid           <= 1'b0;
      m_udp_payload_axis_tvalid <= 1'b0;
      m_udp_payload_axis_tlast  <= 1'b0;
    end else begin
      state_q                   <= state_d;
      ptr_q                     <= ptr_d;
      s_req_ready               <= (state_d == S_IDLE);
      busy                      <= (state_d != S_IDLE);
      m_udp_hdr_valid           <= (state_d == S_HDR);
      m_udp_payload_axis_tvalid <= (state_d == S_PAYLOAD);
      m_udp_payload_axis_tlast  <= (state_d == S_PAYLOAD) &&
                                   (ptr_d == LAST_BEAT);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      rec_q <= pack_record(req);
      src_q <= s_source_ip;
      dst_q <= s_dest_ip;
    end
  end

  always_comb begin
    m_udp_payload_axis_tdata = '0;
    unique case (ptr_q)
      3'd0: m_udp_payload_axis_tdata = rec_q[63:0];
      3'd1: m_udp_payload_axis_tdata = rec_q[127:64];
      3'd2: m_udp_payload_axis_tdata = rec_q[191:128];
      3'd3: m_udp_payload_axis_tdata = rec_q[255:192];
      3'd4: m_udp_payload_axis_tdata = rec_q[319:256];
      3'd5: m_udp_payload_axis_tdata = {32'h0, rec_q[351:320]};
      default: m_udp_payload_axis_tdata = '0;
    endcase
  end

  assign m_udp_payload_axis_tkeep =
    (ptr_q == LAST_BEAT) ? LAST_KEEP : 8'hFF;
  assign m_udp_payload_axis_tuser = 1'b0;

  assign m_ip_dscp         = '0;
  assign m_ip_ecn          = '0;
  assign m_ip_ttl          = IP_TTL;
  assign m_ip_source_ip    = src_q;
  assign m_ip_dest_ip      = dst_q;
  assign m_udp_source_port = SRC_UDP_PORT;
  assign m_udp_dest_port   = DEST_UDP_PORT;
  assign m_udp_length      = UDP_LEN;
  assign m_udp_checksum    = '0;

endmodule

// File: tb/tb_udp_roce_connection_transmitter_64.sv
// Scoreboard bench for the RoCE connection-metadata transmitter.
// Directed requests; a negedge monitor checks header and beats.
module tb_udp_roce_connection_transmitter_64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        s_req_valid;
  logic        s_req_ready;
  logic        s_qp_info_valid;
  logic [23:0] s_rem_qpn, s_loc_qpn, s_rem_psn, s_loc_psn;
  logic [31:0] s_r_key;
  logic [63:0] s_rem_base_addr;
  logic        s_txmeta_valid, s_txmeta_start, s_txmeta_write_type;
  logic [31:0] s_rem_ip_addr;
  logic [63:0] s_rem_addr_offset;
  logic [31:0] s_dma_length;
  logic [15:0] s_rem_udp_port;
  logic [31:0] s_source_ip, s_dest_ip;
  logic        m_udp_hdr_valid;
  logic        m_udp_hdr_ready;
  logic [5:0]  m_ip_dscp;
  logic [1:0]  m_ip_ecn;
  logic [7:0]  m_ip_ttl;
  logic [31:0] m_ip_source_ip, m_ip_dest_ip;
  logic [15:0] m_udp_source_port, m_udp_dest_port;
  logic [15:0] m_udp_length, m_udp_checksum;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid;
  logic        tready = 1'b1;
  logic        tlast;
  logic        tuser;
  logic        busy;

  udp_roce_connection_transmitter_64 dut (
    .clk                       (clk),
    .rst                       (rst),
    .s_req_valid               (s_req_valid),
    .s_req_ready               (s_req_ready),
    .s_qp_info_valid           (s_qp_info_valid),
    .s_rem_qpn                 (s_rem_qpn),
    .s_loc_qpn                 (s_loc_qpn),
    .s_rem_psn                 (s_rem_psn),
    .s_loc_psn                 (s_loc_psn),
    .s_r_key                   (s_r_key),
    .s_rem_base_addr           (s_rem_base_addr),
    .s_txmeta_valid            (s_txmeta_valid),
    .s_txmeta_start            (s_txmeta_start),
    .s_txmeta_write_type       (s_txmeta_write_type),
    .s_rem_ip_addr             (s_rem_ip_addr),
    .s_rem_addr_offset         (s_rem_addr_offset),
    .s_dma_length              (s_dma_length),
    .s_rem_udp_port            (s_rem_udp_port),
    .s_source_ip               (s_source_ip),
    .s_dest_ip                 (s_dest_ip),
    .m_udp_hdr_valid           (m_udp_hdr_valid),
    .m_udp_hdr_ready           (m_udp_hdr_ready),
    .m_ip_dscp                 (m_ip_dscp),
    .m_ip_ecn                  (m_ip_ecn),
    .m_ip_ttl                  (m_ip_ttl),
    .m_ip_source_ip            (m_ip_source_ip),
    .m_ip_dest_ip              (m_ip_dest_ip),
    .m_udp_source_port         (m_udp_source_port),
    .m_udp_dest_port           (m_udp_dest_port),
    .m_udp_length              (m_udp_length),
    .m_udp_checksum            (m_udp_checksum),
    .m_udp_payload_axis_tdata  (tdata),
    .m_udp_payload_axis_tkeep  (tkeep),
    .m_udp_payload_axis_tvalid (tvalid),
    .m_udp_payload_axis_tready (tready),
    .m_udp_payload_axis_tlast  (tlast),
    .m_udp_payload_axis_tuser  (tuser),
    .busy                      (busy)
  );

  typedef struct {
    logic        qpv;
    logic [23:0] rqpn, lqpn, rpsn, lpsn;
    logic [31:0] rkey;
    logic [63:0] base;
    logic        tv, ts, tw;
    logic [31:0] rip;
    logic [63:0] ofs;
    logic [31:0] dma;
    logic [15:0] port;
    logic [31:0] sip, dip;
  } req_t;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  typedef struct {
    logic [31:0] s;
    logic [31:0] d;
  } hdr_t;

  beat_t exp_q[$];
  hdr_t  hq[$];
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (mode)
      0: tready = 1'b1;
      1: tready = 1'($urandom_range(0, 1));
      default: tready = 1'b0;
    endcase
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_expect(input req_t r);
    logic [7:0] b [44];
    beat_t      e;
    hdr_t       h;
    b[0] = {7'd0, r.qpv};
    for (int i = 0; i < 3; i++) begin
      b[1+i]  = r.rqpn[8*(2-i) +: 8];
      b[4+i]  = r.lqpn[8*(2-i) +: 8];
      b[7+i]  = r.rpsn[8*(2-i) +: 8];
      b[10+i] = r.lpsn[8*(2-i) +: 8];
    end
    for (int i = 0; i < 4; i++) begin
      b[13+i] = r.rkey[8*(3-i) +: 8];
      b[26+i] = r.rip[8*(3-i) +: 8];
      b[38+i] = r.dma[8*(3-i) +: 8];
    end
    for (int i = 0; i < 8; i++) begin
      b[17+i] = r.base[8*(7-i) +: 8];
      b[30+i] = r.ofs[8*(7-i) +: 8];
    end
    b[25] = {5'd0, r.tw, r.ts, r.tv};
    b[42] = r.port[15:8];
    b[43] = r.port[7:0];
    for (int j = 0; j < 6; j++) begin
      e.d = '0;
      for (int i = 0; i < 8; i++)
        if (8*j + i < 44) e.d[8*i +: 8] = b[8*j+i];
      e.k = (j == 5) ? 8'h0F : 8'hFF;
      e.l = (j == 5);
      exp_q.push_back(e);
    end
    h.s = r.sip;
    h.d = r.dip;
    hq.push_back(h);
  endtask

  // Monitor / scoreboard
  int          beat_cnt = 0;
  int          frames_done = 0;
  int          lf_beats = 0;
  logic [63:0] cap [6];
  logic [63:0] last_frame [6];
  logic [7:0]  keep5;
  logic        p_stall_b = 0, p_stall_h = 0;
  logic [63:0] p_d;
  logic [7:0]  p_k;
  logic        p_l;
  logic [31:0] p_s, p_dst;
  hdr_t        mh;
  beat_t       mb;

  always @(negedge clk) begin
    if (!rst) begin
      beat_cnt  = 0;
      p_stall_b = 0;
      p_stall_h = 0;
    end else begin
      if (m_udp_hdr_valid) begin
        if (p_stall_h) begin
          chk("hdr_hold_src", m_ip_source_ip, p_s);
          chk("hdr_hold_dst", m_ip_dest_ip, p_dst);
        end
        if (m_udp_hdr_ready) begin
          if (hq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL hdr_unexpected: got header expected none");
          end else begin
            mh = hq.pop_front();
            chk("hdr_src", m_ip_source_ip, mh.s);
            chk("hdr_dst", m_ip_dest_ip, mh.d);
            chk("hdr_ttl", m_ip_ttl, 64'd64);
            chk("hdr_sport", m_udp_source_port, 64'h4321);
            chk("hdr_dport", m_udp_dest_port, 64'h4321);
            chk("hdr_len", m_udp_length, 64'd52);
            chk("hdr_zero", {m_ip_dscp, m_ip_ecn, m_udp_checksum}, 0);
          end
        end
        p_stall_h = !m_udp_hdr_ready;
        p_s       = m_ip_source_ip;
        p_dst     = m_ip_dest_ip;
      end else begin
        p_stall_h = 0;
      end
      if (tvalid) begin
        if (p_stall_b) begin
          chk("beat_hold_data", tdata, p_d);
          chk("beat_hold_keep", tkeep, p_k);
          chk("beat_hold_last", tlast, p_l);
        end
        if (tready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL beat_unexpected: got %h expected none", tdata);
          end else begin
            mb = exp_q.pop_front();
            chk("beat_data", tdata, mb.d);
            chk("beat_keep", tkeep, mb.k);
            chk("beat_last", tlast, mb.l);
            chk("beat_tuser", tuser, 0);
          end
          if (beat_cnt < 6) cap[beat_cnt] = tdata;
          if (beat_cnt == 5) keep5 = tkeep;
          beat_cnt++;
          if (tlast) begin
            last_frame  = cap;
            lf_beats    = beat_cnt;
            beat_cnt    = 0;
            frames_done++;
          end
        end
        p_stall_b = !tready;
        p_d = tdata;
        p_k = tkeep;
        p_l = tlast;
      end else begin
        p_stall_b = 0;
      end
    end
  end

  task automatic drive(input req_t r);
    s_qp_info_valid     = r.qpv;
    s_rem_qpn           = r.rqpn;
    s_loc_qpn           = r.lqpn;
    s_rem_psn           = r.rpsn;
    s_loc_psn           = r.lpsn;
    s_r_key             = r.rkey;
    s_rem_base_addr     = r.base;
    s_txmeta_valid      = r.tv;
    s_txmeta_start      = r.ts;
    s_txmeta_write_type = r.tw;
    s_rem_ip_addr       = r.rip;
    s_rem_addr_offset   = r.ofs;
    s_dma_length        = r.dma;
    s_rem_udp_port      = r.port;
    s_source_ip         = r.sip;
    s_dest_ip           = r.dip;
  endtask

  // Called just after a clock edge; returns just after the accept edge.
  task automatic send(input req_t r, output int acc);
    int n;
    n = 0;
    drive(r);
    s_req_valid = 1'b1;
    push_expect(r);
    forever begin
      @(posedge clk);
      n++;
      if (s_req_ready || n >= 100) break;
    end
    #1;
    s_req_valid = 1'b0;
    acc = cyc;
    if (n >= 100) begin
      tests++;
      fails++;
      $display("FAIL req_accept_timeout: got no accept expected accept");
    end
  endtask

  task automatic wait_frame(input int target);
    int n;
    bit bad;
    n   = 0;
    bad = 0;
    while (frames_done < target && n < 400) begin
      @(posedge clk);
      n++;
      if (frames_done < target && s_req_ready) bad = 1;
    end
    #1;
    if (n >= 400) begin
      tests++;
      fails++;
      $display("FAIL frame_timeout: got %0d frames expected %0d",
               frames_done, target);
    end
    chk("req_ready_low_in_frame", bad, 0);
    chk("req_ready_after_tlast", s_req_ready, 1);
    chk("beats_per_frame", lf_beats, 6);
  endtask

  function automatic logic [7:0] fb(input int k);
    logic [63:0] w;
    w = last_frame[k/8];
    return w[8*(k%8) +: 8];
  endfunction

  initial begin
    req_t r1, r2, r3a, r3b, r4, r5, r6;
    int   a1, a2, f0, n;

    r1  = '{1'b1, 24'h123456, 24'hABCDEF, 24'h000102, 24'h0A0B0C,
            32'hDEADBEEF, 64'h0011223344556677, 1'b1, 1'b1, 1'b1,
            32'hC0A80002, 64'h0000000000001000, 32'h00000400,
            16'h4321, 32'hC0A80001, 32'hC0A80002};
    r2  = '{1'b0, 24'h0F0E0D, 24'h1A2B3C, 24'hFFFFFF, 24'h000001,
            32'h01020304, 64'h8877665544332211, 1'b1, 1'b0, 1'b1,
            32'h0A000001, 64'hFFFFFFFF00000000, 32'h12345678,
            16'hBEEF, 32'h0A000002, 32'h0A000003};
    r3a = '{1'b1, 24'h111111, 24'h222222, 24'h333333, 24'h444444,
            32'h55555555, 64'h6666666677777777, 1'b0, 1'b1, 1'b0,
            32'h88888888, 64'h99999999AAAAAAAA, 32'hBBBBBBBB,
            16'hCCCC, 32'hDDDDDDDD, 32'hEEEEEEEE};
    r3b = '{1'b0, 24'hA5A5A5, 24'h5A5A5A, 24'hC3C3C3, 24'h3C3C3C,
            32'hF0F0F0F0, 64'h0F0F0F0F0F0F0F0F, 1'b1, 1'b1, 1'b0,
            32'h01010101, 64'h0202020202020202, 32'h03030303,
            16'h0404, 32'h05050505, 32'h06060606};
    r4  = '{1'b1, 24'h000000, 24'h000000, 24'h000000, 24'h000000,
            32'h00000000, 64'h0, 1'b1, 1'b0, 1'b0,
            32'h00000000, 64'h0, 32'h00010000,
            16'h12B7, 32'h01000001, 32'h01000002};
    r5  = r1;
    r6  = '{1'b1, 24'h00ABCD, 24'h00DCBA, 24'h100000, 24'h200000,
            32'hCAFEF00D, 64'h0000100000000000, 1'b1, 1'b1, 1'b0,
            32'hAC100001, 64'h0000000000002000, 32'h00100000,
            16'h4321, 32'hAC100002, 32'hAC100001};

    rst             = 1'b1;
    s_req_valid     = 1'b0;
    m_udp_hdr_ready = 1'b1;
    drive(r1);
    #1 rst = 1'b0;
    #2;
    chk("rst_req_ready", s_req_ready, 0);
    chk("rst_hdr_valid", m_udp_hdr_valid, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk("rel_req_ready_pre", s_req_ready, 0);
    @(posedge clk);
    #1;
    chk("rel_req_ready_post", s_req_ready, 1);

    // Directed record contents
    send(r1, a1);
    chk("busy_after_accept", busy, 1);
    wait_frame(1);
    chk("t1_beat0", last_frame[0], 64'h00EFCDAB56341201);
    chk("t1_beat2", last_frame[2], 64'h66554433221100EF);
    chk("t1_beat3_b1", last_frame[3][15:8], 8'h07);
    chk("t1_beat5_keep", keep5, 8'h0F);

    // Header stall then random payload backpressure
    m_udp_hdr_ready = 1'b0;
    send(r2, a1);
    repeat (5) @(posedge clk);
    #1;
    chk("stall_hdr_valid", m_udp_hdr_valid, 1);
    chk("stall_tvalid", tvalid, 0);
    m_udp_hdr_ready = 1'b1;
    mode = 1;
    wait_frame(2);
    mode = 0;
    @(posedge clk);
    #1;

    // Back-to-back with inputs changed after acceptance
    send(r3a, a1);
    chk("b2b_ready_low", s_req_ready, 0);
    send(r3b, a2);
    chk("b2b_period", 64'(a2 - a1), 8);
    wait_frame(4);
    @(posedge clk);
    #1;

    // Length and port field placement
    send(r4, a1);
    wait_frame(5);
    chk("t4_beat4_hi", last_frame[4][63:48], 16'h0100);
    chk("t4_beat5_lo", last_frame[5][31:0], 32'hB7120000);
    chk("t4_beat5_hi", last_frame[5][63:32], 0);
    @(posedge clk);
    #1;

    // Reset during beat 3
    f0 = frames_done;
    send(r5, a1);
    n = 0;
    forever begin
      @(posedge clk);
      n++;
      if (beat_cnt == 3 || n >= 50) break;
    end
    mode = 2;
    chk("abort_reached_beat3", beat_cnt, 3);
    #2 rst = 1'b0;
    #1;
    chk("abort_tvalid", tvalid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_tlast", tlast, 0);
    chk("abort_req_ready", s_req_ready, 0);
    chk("abort_no_frame", frames_done, f0);
    exp_q.delete();
    hq.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    mode = 0;
    chk("abort_rel_ready_pre", s_req_ready, 0);
    @(posedge clk);
    #1;
    chk("abort_rel_ready_post", s_req_ready, 1);

    // Fresh frame decoded as the receiver would
    send(r6, a1);
    wait_frame(f0 + 1);
    chk("lb_rem_qpn", {fb(1), fb(2), fb(3)}, r6.rqpn);
    chk("lb_loc_qpn", {fb(4), fb(5), fb(6)}, r6.lqpn);
    chk("lb_rem_psn", {fb(7), fb(8), fb(9)}, r6.rpsn);
    chk("lb_loc_psn", {fb(10), fb(11), fb(12)}, r6.lpsn);
    chk("lb_r_key", {fb(13), fb(14), fb(15), fb(16)}, r6.rkey);
    chk("lb_dma", {fb(38), fb(39), fb(40), fb(41)}, r6.dma);
    chk("lb_rem_addr",
        {fb(17), fb(18), fb(19), fb(20), fb(21), fb(22), fb(23), fb(24)} +
        {fb(30), fb(31), fb(32), fb(33), fb(34), fb(35), fb(36), fb(37)},
        64'h0000100000002000);
    chk("lb_start", fb(25) & 8'h03, 8'h03);

    repeat (3) @(posedge clk);
    chk("queues_empty", exp_q.size() + hq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
